dm_lsu: RTL and testbench

Parametrised data-memory load/store unit. It is the next generation of the dm_1k word/byte data memory.
- Byte-addressed, little-endian storage.
- Byte, half and word accesses, with signed or unsigned load extension.
- Request/response handshake with configurable read latency.
- Optional misalignment trapping.
- Sits between the CPU's memory stage and on-chip data RAM, with a single outstanding request.

---
 rtl/dm_lsu_pkg.sv | 35 +++
 rtl/dm_lsu_if.sv | 25 ++
 rtl/dm_lsu_ram.sv | 24 ++
 rtl/dm_lsu.sv | 122 ++++++++++++
 tb/tb_dm_lsu.sv | 202 ++++++++++++++++++++
 5 files changed

// File: rtl/dm_lsu_pkg.sv
// Shared definitions for the dm_lsu load/store unit: size encodings, FSM states
// and the little-endian lane extract/extend helper.
package dm_pkg;

    localparam logic [1:0] DM_BYTE = 2'b00;
    localparam logic [1:0] DM_HALF = 2'b01;
    localparam logic [1:0] DM_WORD = 2'b10;
    localparam logic [1:0] DM_RSVD = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } dm_state_e;

    // Picks the addressed byte/half out of a stored word and sign/zero extends it.
    function automatic logic [31:0] dm_extract(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        uns);
        logic [7:0]  b;
        logic [15:0] h;
        logic [31:0] r;
        b = 8'(word >> {lane, 3'b000});
        h = lane[1] ? word[31:16] : word[15:0];
        case (size)
            DM_BYTE: r = uns ? {24'h0, b} : {{24{b[7]}}, b};
            DM_HALF: r = uns ? {16'h0, h} : {{16{h[15]}}, h};
            DM_WORD: r = word;
            default: r = '0;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/dm_lsu_if.sv
// Request/response bus between the memory stage (master) and dm_lsu (slave).
interface dm_lsu_if #(
    parameter int unsigned ADDR_W = 10
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [1:0]        req_size;
    logic              req_unsigned;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic              rsp_valid;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_size, req_unsigned, req_addr, req_wdata,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface

// File: rtl/dm_lsu_ram.sv
// Word-organised data RAM: byte-enable synchronous write, combinational read, no reset.
module dm_ram #(
    parameter int unsigned WA_W  = 8,
    parameter int unsigned DEPTH = 256
) (
    input  logic            clk,
    input  logic            we,
    input  logic [3:0]      be,
    input  logic [WA_W-1:0] addr,
    input  logic [31:0]     wdata,
    output logic [31:0]     rdata
);
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int unsigned i = 0; i < 4; i++) begin
                if (be[i]) mem[addr][8*i +: 8] <= wdata[8*i +: 8];
            end
        end
    end

    assign rdata = mem[addr];
endmodule

// File: rtl/dm_lsu.sv
// Byte-addressed little-endian load/store unit with configurable read latency.
// Optional misalignment trapping is enabled by defining DM_ALIGN_CHECK_EN.
module dm_lsu
    import dm_pkg::*;
#(
    parameter int unsigned ADDR_W  = 10,
    parameter int unsigned LATENCY = 1
) (
    input logic     clk,
    input logic     rst_n,
    dm_lsu_if.slave bus
);
    localparam int unsigned WA_W     = (ADDR_W > 2) ? ADDR_W - 2 : 1;
    localparam logic [2:0]  CNT_INIT = (LATENCY > 1) ? 3'(LATENCY - 2) : 3'd0;

    dm_state_e       state, state_n;
    logic [2:0]      cnt, cnt_n;
    logic            accept, misalign, err, wr_en;
    logic [1:0]      lane;
    logic [3:0]      be;
    logic [WA_W-1:0] widx;
    logic [31:0]     wdata_rep, ram_rdata, ld_data;
    logic [31:0]     hold_data, rdata_q;
    logic            hold_err, err_q;

    assign lane   = bus.req_addr[1:0];
    assign widx   = WA_W'(bus.req_addr >> 2);
    assign accept = bus.req_valid && bus.req_ready;

`ifdef DM_ALIGN_CHECK_EN
    assign misalign = (bus.req_size == DM_HALF && lane[0]) ||
                      (bus.req_size == DM_WORD && lane != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    assign err     = (bus.req_size == DM_RSVD) || misalign;
    assign wr_en   = accept && bus.req_we && !err;
    assign ld_data = (err || bus.req_we) ? '0
                   : dm_extract(ram_rdata, bus.req_size, lane, bus.req_unsigned);

    always_comb begin
        be        = '0;
        wdata_rep = bus.req_wdata;
        case (bus.req_size)
            DM_BYTE: begin
                be        = 4'b0001 << lane;
                wdata_rep = {4{bus.req_wdata[7:0]}};
            end
            DM_HALF: begin
                be        = lane[1] ? 4'b1100 : 4'b0011;
                wdata_rep = {2{bus.req_wdata[15:0]}};
            end
            DM_WORD: be = 4'b1111;
            default: be = '0;
        endcase
    end

    dm_ram #(
        .WA_W  (WA_W),
        .DEPTH (2 ** (ADDR_W - 2))
    ) u_ram (
        .clk   (clk),
        .we    (wr_en),
        .be    (be),
        .addr  (widx),
        .wdata (wdata_rep),
        .rdata (ram_rdata)
    );

    always_comb begin
        state_n = state;
        cnt_n   = cnt;
        case (state)
            IDLE, RESP: begin
                if (accept) begin
                    if (LATENCY == 1) begin
                        state_n = RESP;
                    end else begin
                        state_n = WAIT;
                        cnt_n   = CNT_INIT;
                    end
                end else begin
                    state_n = IDLE;
                end
            end
            WAIT: begin
                if (cnt != 3'd0) cnt_n = cnt - 3'd1;
                else             state_n = RESP;
            end
            default: state_n = IDLE;
        endcase
    end

    // Response registers change only on entry to RESP; a WAIT path releases the captured load.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            cnt       <= '0;
            hold_data <= '0;
            hold_err  <= 1'b0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
        end else begin
            state <= state_n;
            cnt   <= cnt_n;
            if (accept) begin
                hold_data <= ld_data;
                hold_err  <= err;
            end
            if (state_n == RESP) begin
                rdata_q <= (state == WAIT) ? hold_data : ld_data;
                err_q   <= (state == WAIT) ? hold_err  : err;
            end
        end
    end

    assign bus.req_ready = (state != WAIT);
    assign bus.rsp_valid = (state == RESP);
    assign bus.rsp_rdata = rdata_q;
    assign bus.rsp_err   = err_q;
endmodule

// File: tb/tb_dm_lsu.sv
// Directed scoreboard bench for dm_lsu at LATENCY=1 and LATENCY=3.
module tb_dm_lsu;
    import dm_pkg::*;

    typedef struct {
        logic [31:0] rd;
        logic        err;
        int unsigned due;
    } exp_t;

    logic        clk;
    logic        rst_n;
    int unsigned cyc;
    int unsigned checks;
    int unsigned passes;
    exp_t        q1[$];
    exp_t        q3[$];

    dm_lsu_if #(.ADDR_W(10)) if1();
    dm_lsu_if #(.ADDR_W(10)) if3();

    dm_lsu #(.ADDR_W(10), .LATENCY(1)) u_l1 (.clk(clk), .rst_n(rst_n), .bus(if1));
    dm_lsu #(.ADDR_W(10), .LATENCY(3)) u_l3 (.clk(clk), .rst_n(rst_n), .bus(if3));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: got %h, expected %h", tag, obs, exp);
    endtask

    task automatic drive(input bit d3, input bit v, input bit we, input logic [1:0] sz,
                         input bit un, input logic [9:0] a, input logic [31:0] wd);
        if (d3) begin
            if3.req_valid = v; if3.req_we = we; if3.req_size = sz;
            if3.req_unsigned = un; if3.req_addr = a; if3.req_wdata = wd;
        end else begin
            if1.req_valid = v; if1.req_we = we; if1.req_size = sz;
            if1.req_unsigned = un; if1.req_addr = a; if1.req_wdata = wd;
        end
    endtask

    // Presents a request, waits (bounded) for ready, records the expected response.
    task automatic issue(input bit d3, input bit we, input logic [1:0] sz, input bit un,
                         input logic [9:0] a, input logic [31:0] wd,
                         input logic [31:0] erd, input logic eerr);
        int unsigned t;
        exp_t e;
        @(negedge clk);
        drive(d3, 1'b1, we, sz, un, a, wd);
        t = 0;
        while (!(d3 ? if3.req_ready : if1.req_ready) && t < 20) begin
            @(negedge clk);
            t++;
        end
        if (t >= 20) chk("ready_timeout", {31'd0, d3 ? if3.req_ready : if1.req_ready}, 32'd1);
        e.rd  = erd;
        e.err = eerr;
        e.due = cyc + (d3 ? 3 : 1);
        if (d3) q3.push_back(e);
        else    q1.push_back(e);
        @(posedge clk);
    endtask

    task automatic idle(input bit d3);
        @(negedge clk);
        drive(d3, 1'b0, 1'b0, DM_WORD, 1'b0, 10'd0, 32'd0);
    endtask

    always @(negedge clk) begin
        exp_t e;
        if (if1.rsp_valid === 1'b1) begin
            checks++;
            assert (q1.size() > 0) passes++;
            else $error("FAIL l1_stray: rsp_valid with %0d pending, expected >0", q1.size());
            if (q1.size() > 0) begin
                e = q1.pop_front();
                chk("l1_rdata", if1.rsp_rdata, e.rd);
                chk("l1_err", {31'd0, if1.rsp_err}, {31'd0, e.err});
                chk("l1_latency", cyc, e.due);
            end
        end
        if (if3.rsp_valid === 1'b1) begin
            checks++;
            assert (q3.size() > 0) passes++;
            else $error("FAIL l3_stray: rsp_valid with %0d pending, expected >0", q3.size());
            if (q3.size() > 0) begin
                e = q3.pop_front();
                chk("l3_rdata", if3.rsp_rdata, e.rd);
                chk("l3_err", {31'd0, if3.rsp_err}, {31'd0, e.err});
                chk("l3_latency", cyc, e.due);
            end
        end
    end

    initial begin
        checks = 0;
        passes = 0;
        rst_n  = 1'b0;
        drive(1'b0, 1'b0, 1'b0, DM_WORD, 1'b0, 10'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, DM_WORD, 1'b0, 10'd0, 32'd0);
        #1;
        chk("rst_ready1", {31'd0, if1.req_ready}, 32'd1);
        chk("rst_valid1", {31'd0, if1.rsp_valid}, 32'd0);
        chk("rst_rdata1", if1.rsp_rdata, 32'd0);
        chk("rst_err1", {31'd0, if1.rsp_err}, 32'd0);
        chk("rst_ready3", {31'd0, if3.req_ready}, 32'd1);
        chk("rst_valid3", {31'd0, if3.rsp_valid}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // LATENCY=1: word round trip, back-to-back loads, byte extension
        issue(0, 1, DM_WORD, 0, 10'd0, 32'h12345678, 32'h0, 0);
        issue(0, 0, DM_WORD, 0, 10'd0, 32'h0, 32'h12345678, 0);
        issue(0, 0, DM_WORD, 0, 10'd0, 32'h0, 32'h12345678, 0);
        issue(0, 0, DM_BYTE, 0, 10'd0, 32'h0, 32'h00000078, 0);
        issue(0, 0, DM_BYTE, 0, 10'd3, 32'h0, 32'h00000012, 0);
        idle(0);
        issue(0, 1, DM_BYTE, 0, 10'd0, 32'h00000087, 32'h0, 0);
        issue(0, 0, DM_BYTE, 0, 10'd0, 32'h0, 32'hFFFFFF87, 0);
        issue(0, 0, DM_BYTE, 1, 10'd0, 32'h0, 32'h00000087, 0);
        issue(0, 0, DM_WORD, 0, 10'd0, 32'h0, 32'h12345687, 0);

        // Misaligned and reserved accesses
`ifdef DM_ALIGN_CHECK_EN
        issue(0, 0, DM_WORD, 0, 10'd1, 32'h0, 32'h0, 1);
        issue(0, 0, DM_HALF, 1, 10'd1, 32'h0, 32'h0, 1);
        issue(0, 1, DM_WORD, 0, 10'd2, 32'hDEADBEEF, 32'h0, 1);
        issue(0, 0, DM_WORD, 0, 10'd0, 32'h0, 32'h12345687, 0);
`else
        issue(0, 0, DM_WORD, 0, 10'd1, 32'h0, 32'h12345687, 0);
        issue(0, 0, DM_HALF, 1, 10'd1, 32'h0, 32'h00005687, 0);
        issue(0, 1, DM_WORD, 0, 10'd2, 32'hDEADBEEF, 32'h0, 0);
        issue(0, 0, DM_WORD, 0, 10'd0, 32'h0, 32'hDEADBEEF, 0);
`endif
        issue(0, 1, DM_WORD, 0, 10'd0, 32'h12345687, 32'h0, 0);
        issue(0, 0, DM_RSVD, 0, 10'd0, 32'h0, 32'h0, 1);
        issue(0, 1, DM_RSVD, 0, 10'd0, 32'hFFFFFFFF, 32'h0, 1);
        issue(0, 0, DM_WORD, 0, 10'd0, 32'h0, 32'h12345687, 0);

        // Half-word access and extension
        issue(0, 0, DM_HALF, 0, 10'd2, 32'h0, 32'h00001234, 0);
        issue(0, 1, DM_HALF, 0, 10'd2, 32'h00008001, 32'h0, 0);
        issue(0, 0, DM_HALF, 0, 10'd2, 32'h0, 32'hFFFF8001, 0);
        issue(0, 0, DM_HALF, 1, 10'd2, 32'h0, 32'h00008001, 0);
        idle(0);

        // LATENCY=3: ready drops for two cycles, held request waits for RESP
        issue(1, 1, DM_WORD, 0, 10'd4, 32'hA5A50F0F, 32'h0, 0);
        issue(1, 0, DM_WORD, 0, 10'd4, 32'h0, 32'hA5A50F0F, 0);
        @(negedge clk);
        chk("l3_ready_w1", {31'd0, if3.req_ready}, 32'd0);
        @(negedge clk);
        chk("l3_ready_w2", {31'd0, if3.req_ready}, 32'd0);
        issue(1, 0, DM_BYTE, 1, 10'd4, 32'h0, 32'h0000000F, 0);
        issue(1, 0, DM_HALF, 0, 10'd6, 32'h0, 32'hFFFFA5A5, 0);
        idle(1);
        issue(1, 1, DM_BYTE, 0, 10'd5, 32'h0000003C, 32'h0, 0);
        issue(1, 0, DM_WORD, 0, 10'd4, 32'h0, 32'hA5A53C0F, 0);
        idle(1);
        repeat (4) @(negedge clk);

        // Reset while a store sits in WAIT: response dropped, write kept
        issue(1, 1, DM_WORD, 0, 10'd8, 32'h11112222, 32'h0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        drive(1'b0, 1'b0, 1'b0, DM_WORD, 1'b0, 10'd0, 32'd0);
        drive(1'b1, 1'b0, 1'b0, DM_WORD, 1'b0, 10'd0, 32'd0);
        #1;
        chk("mid_rst_valid", {31'd0, if3.rsp_valid}, 32'd0);
        chk("mid_rst_ready", {31'd0, if3.req_ready}, 32'd1);
        chk("mid_rst_pending", q3.size(), 32'd1);
        if (q3.size() > 0) void'(q3.pop_front());
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("post_rst_ready", {31'd0, if3.req_ready}, 32'd1);
        repeat (6) @(negedge clk);
        issue(1, 0, DM_WORD, 0, 10'd8, 32'h0, 32'h11112222, 0);
        issue(1, 0, DM_WORD, 0, 10'd4, 32'h0, 32'hA5A53C0F, 0);
        idle(1);
        issue(0, 0, DM_WORD, 0, 10'd0, 32'h0, 32'h80015687, 0);
        idle(0);

        repeat (8) @(negedge clk);
        chk("l1_drained", q1.size(), 32'd0);
        chk("l3_drained", q3.size(), 32'd0);
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
